// File: rtl/sd_pkg.sv
// Shared definitions for the SPI-mode SD write path: feeder state encoding,
// sector size and the data token shared with the block writer.
package sd_pkg;
    localparam int         SD_SEC_BYTES   = 512;
    localparam logic [7:0] SD_TOKEN_START = 8'hFE;

    typedef enum logic [2:0] {
        FEED_IDLE,
        FEED_FILL,
        FEED_REQ,
        FEED_WAIT_DATA,
        FEED_SEND,
        FEED_WAIT_DONE
    } feed_state_t;
endpackage

// File: rtl/sd_sector_feeder_if.sv
// Capture byte stream plus block-writer handshake seen by the sector feeder.
// master = feeder side, slave = capture source / SD writer side.
interface sd_sector_feeder_if;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        write_req;
    logic [31:0] sec;
    logic        data_phase;
    logic        CMOS_SD;
    logic        wr_done;

    modport master (input in_data, in_valid, data_phase, wr_done,
                    output in_ready, write_req, sec, CMOS_SD);
    modport slave  (output in_data, in_valid, data_phase, wr_done,
                    input in_ready, write_req, sec, CMOS_SD);
endinterface

// File: rtl/sd_sector_ram.sv
// Simple dual-port sector buffer: one byte write port, one registered read port.
module sd_sector_ram #(
    parameter int AW = 9
) (
    input  logic          SD_clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);
    logic [7:0] mem [0:(1<<AW)-1];

    always_ff @(posedge SD_clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/sd_sector_feeder.sv
// Buffers capture bytes into sectors, requests a block write per sector and
// serialises the sector MSB-first during the writer's data phase.
// Optional build macro PINGPONG_EN: two banks so filling overlaps draining.
module sd_sector_feeder
    import sd_pkg::*;
#(
    parameter int          SEC_BYTES = SD_SEC_BYTES,
    parameter logic [31:0] SEC_LIMIT = 32'd65536,
    parameter int          AW        = $clog2(SEC_BYTES)
) (
    input  logic               SD_clk,
    input  logic               SD_rst,
    input  logic               start,
    input  logic [31:0]        base_sec,
    sd_sector_feeder_if.master bus,
    output logic               busy,
    output logic [31:0]        sec_count,
    output logic               all_done
);
    localparam logic [AW-1:0] LAST = AW'(SEC_BYTES - 1);

    feed_state_t   state, state_nxt;
    logic [31:0]   base_q, sec_q, cnt_inc;
    logic [AW-1:0] wr_ptr, rd_ptr, raddr;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg, rd_data;
    logic          cmos_q, dp_q, done_q;
    logic          in_rdy, acc, dp_rise, done_rise, send_last, fill_done;

    assign acc       = bus.in_valid && in_rdy;
    assign dp_rise   = bus.data_phase && !dp_q;
    assign done_rise = bus.wr_done && !done_q;
    assign send_last = (bit_idx == 3'd0) && (rd_ptr == LAST);
    assign cnt_inc   = sec_count + 32'd1;

    assign bus.in_ready = in_rdy;
    assign bus.sec      = sec_q;
    assign bus.CMOS_SD  = cmos_q;

`ifdef PINGPONG_EN
    logic [1:0]      full;
    logic            fb, db;
    logic [1:0][7:0] rd_bank;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        sd_sector_ram #(.AW(AW)) u_ram (
            .SD_clk (SD_clk),
            .we     (acc && (fb == 1'(b))),
            .waddr  (wr_ptr),
            .wdata  (bus.in_data),
            .raddr  (raddr),
            .rdata  (rd_bank[b])
        );
    end
    assign rd_data = rd_bank[db];
    // Bank order is strict: the drain bank is requested as soon as it fills.
    assign fill_done = full[db] || (acc && (wr_ptr == LAST) && (fb == db));

    always_ff @(posedge SD_clk) begin
        if (SD_rst || (state == FEED_IDLE && start)) begin
            full <= 2'b00;
            fb   <= 1'b0;
            db   <= 1'b0;
        end else begin
            if (acc && wr_ptr == LAST) begin
                full[fb] <= 1'b1;
                fb       <= ~fb;
            end
            if (state == FEED_WAIT_DONE && done_rise) begin
                full[db] <= 1'b0;
                db       <= ~db;
            end
        end
    end
`else
    sd_sector_ram #(.AW(AW)) u_ram (
        .SD_clk (SD_clk),
        .we     (acc),
        .waddr  (wr_ptr),
        .wdata  (bus.in_data),
        .raddr  (raddr),
        .rdata  (rd_data)
    );
    assign fill_done = acc && (wr_ptr == LAST);
`endif

    always_comb begin
        state_nxt     = state;
        bus.write_req = (state == FEED_REQ) || (state == FEED_WAIT_DATA);
        busy          = (state != FEED_IDLE) && (state != FEED_FILL);
        // Prefetch the next byte so the serial stream has no bubble between bytes.
        raddr         = (state == FEED_SEND) ? rd_ptr + 1'b1 : '0;
`ifdef PINGPONG_EN
        in_rdy        = (state != FEED_IDLE) && !full[fb];
`else
        in_rdy        = (state == FEED_FILL);
`endif
        unique case (state)
            FEED_IDLE:      if (start) state_nxt = (SEC_LIMIT == 32'd0) ? FEED_IDLE : FEED_FILL;
            FEED_FILL:      if (fill_done) state_nxt = FEED_REQ;
            FEED_REQ:       state_nxt = FEED_WAIT_DATA;
            FEED_WAIT_DATA: if (dp_rise) state_nxt = FEED_SEND;
            FEED_SEND:      if (!bus.data_phase || send_last) state_nxt = FEED_WAIT_DONE;
            FEED_WAIT_DONE: if (done_rise) state_nxt = (cnt_inc == SEC_LIMIT) ? FEED_IDLE : FEED_FILL;
            default:        state_nxt = FEED_IDLE;
        endcase
    end

    always_ff @(posedge SD_clk) begin
        if (SD_rst) begin
            state     <= FEED_IDLE;
            base_q    <= '0;
            sec_q     <= '0;
            cmos_q    <= 1'b1;
            sec_count <= '0;
            all_done  <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            bit_idx   <= 3'd7;
            shreg     <= '0;
            dp_q      <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state  <= state_nxt;
            dp_q   <= bus.data_phase;
            done_q <= bus.wr_done;
            if (acc) wr_ptr <= wr_ptr + 1'b1;
            unique case (state)
                FEED_IDLE: if (start) begin
                    base_q    <= base_sec;
                    sec_count <= '0;
                    wr_ptr    <= '0;
                    all_done  <= (SEC_LIMIT == 32'd0);
                end
                FEED_FILL: if (fill_done) sec_q <= base_q + sec_count;
                FEED_WAIT_DATA: if (dp_rise) begin
                    cmos_q  <= rd_data[7];
                    shreg   <= {rd_data[6:0], 1'b0};
                    bit_idx <= 3'd7;
                    rd_ptr  <= '0;
                end
                FEED_SEND: begin
                    if (!bus.data_phase || send_last) begin
                        cmos_q <= 1'b1;
                    end else if (bit_idx == 3'd0) begin
                        cmos_q  <= rd_data[7];
                        shreg   <= {rd_data[6:0], 1'b0};
                        bit_idx <= 3'd7;
                        rd_ptr  <= rd_ptr + 1'b1;
                    end else begin
                        cmos_q  <= shreg[7];
                        shreg   <= {shreg[6:0], 1'b0};
                        bit_idx <= bit_idx - 1'b1;
                    end
                end
                FEED_WAIT_DONE: if (done_rise) begin
                    sec_count <= cnt_inc;
                    if (cnt_inc == SEC_LIMIT) all_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
